hazard_bubble_ctrl: RTL and testbench
=====================================

# hazard_bubble_ctrl

Parametrised ID-stage hazard controller and ID/EX control-bundle register for the pipelined CPU. It detects load-use hazards and stalls PC and IF/ID for a configurable number of cycles, loading an all-zero control bundle (bubble) into ID/EX on every stall cycle. It also flushes ID/EX on a taken branch or jump, and freezes on an external memory stall. It replaces the combinational control-zeroing mux in front of the ID/EX register.

## Interface
Parameters:
- CTRL_W, 12, width of the packed control bundle.
- REG_W, 5, register-specifier width.
- LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the bubble counter (only with HAZARD_STATS_EN).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ctrl_i  in  CTRL_W  control bundle from the main decoder for the ID instruction.
- id_rs_i  in  REG_W  rs of the ID instruction.
- id_rt_i  in  REG_W  rt of the ID instruction.
- id_uses_rt_i  in  1  ID instruction reads rt as a source.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rt_i  in  REG_W  destination of the EX load.
- flush_i  in  1  taken branch or jump resolved this cycle.
- freeze_i  in  1  memory stall; the whole front end holds.
- ctrl_o  out  CTRL_W  registered ID/EX control bundle.
- pc_write_o  out  1  PC write enable.
- ifid_write_o  out  1  IF/ID write enable.
- bubble_o  out  1  a zero bundle is loaded at the next edge.
- bubble_cnt_o  out  CNT_W  bubble count; present only with HAZARD_STATS_EN.

## Operation
- Hazard condition: `hz = ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i))`.
- FSM states:
  - IDLE.
  - STALL, with down-counter `cnt` of 3 bits.
- Priority, per cycle: rst_i > freeze_i > flush_i > STALL > hz > normal.
- Freeze (freeze_i=1), in any state:
  - ctrl_o, state and cnt hold.
  - pc_write_o=0, ifid_write_o=0, bubble_o=0.
- Flush (freeze_i=0, flush_i=1):
  - ctrl_o←0 and the FSM goes to IDLE with cnt←0.
  - pc_write_o=1, ifid_write_o=1, bubble_o=1.
  - A concurrent hz or active STALL is discarded.
- STALL (no freeze, no flush):
  - ctrl_o←0; pc_write_o=0, ifid_write_o=0, bubble_o=1.
  - If cnt==0 go to IDLE, else cnt←cnt−1.
  - hz is ignored.
- IDLE with hz:
  - ctrl_o←0; pc_write_o=0, ifid_write_o=0, bubble_o=1.
  - If LOAD_STALL>1: go to STALL with cnt←LOAD_STALL−2. Otherwise stay in IDLE.
- IDLE without hz (normal):
  - ctrl_o←ctrl_i; pc_write_o=1, ifid_write_o=1, bubble_o=0.
- Total stall per hazard: exactly LOAD_STALL cycles, not counting freeze cycles, which extend the stall without consuming it.

## Timing
- pc_write_o, ifid_write_o and bubble_o are combinational from the inputs, state and rst_i; they take effect in the same cycle.
- ctrl_o has one-cycle latency: the value selected in cycle N appears after edge N.
- Reset (rst_i=1, asynchronous):
  - Registers: ctrl_o=0, state=IDLE, cnt=0, bubble_cnt_o=0.
  - Combinational outputs while rst_i is high: pc_write_o=0, ifid_write_o=0, bubble_o=0.
- Reset deasserted mid-stall: the FSM restarts in IDLE and the stall is not resumed.
- ex_rt_i==0 never stalls.
- Back-to-back hazards re-detect in IDLE on the cycle after a stall ends.

## Configuration
- HAZARD_STATS_EN defined:
  - bubble_cnt_o exists.
  - It increments on every edge where bubble_o=1 and rst_i=0.
  - It saturates at 2^CNT_W−1, with no wrap.
- HAZARD_STATS_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst_i=1 with ctrl_i=12'hFFF → ctrl_o=0, pc_write_o=0, ifid_write_o=0. After release, ctrl_i=12'h0A5 with no hazard → ctrl_o=12'h0A5 after one edge.
- Load-use, LOAD_STALL=1: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 → pc_write_o=0 and bubble_o=1 that cycle, ctrl_o=0 after the edge. The next cycle, with ex_memread_i=0, gives ctrl_o=ctrl_i.
- Multi-cycle, LOAD_STALL=3: hazard for one cycle, then ex inputs cleared → pc_write_o=0 for exactly 3 consecutive cycles and ctrl_o=0 for 3 edges.
- Rt source: ex_rt_i=9, id_rt_i=9 with id_uses_rt_i=0 → no stall. With id_uses_rt_i=1 → stall. ex_rt_i=0 matching rs → no stall.
- Freeze mid-stall (LOAD_STALL=3): freeze_i=1 for 2 cycles in stall cycle 2 → ctrl_o holds and bubble_o=0 during the freeze. The stall then completes with 2 more stalled cycles.
- Flush with hazard, HAZARD_STATS_EN: flush_i=1 and hz=1 together → pc_write_o=1, ctrl_o=0, FSM in IDLE. bubble_cnt_o increments by 1. With CNT_W=2, after 5 bubbles → bubble_cnt_o=3.

Source files
------------

// File: rtl/hazard_bubble_ctrl.sv
// rtl/hazard_bubble_ctrl.sv - ID-stage load-use hazard controller and ID/EX control register
// Optional bubble statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_bubble_ctrl #(
   parameter int CTRL_W     = 12,
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [REG_W-1:0]  id_rs_i,
   input  logic [REG_W-1:0]  id_rt_i,
   input  logic              id_uses_rt_i,
   input  logic              ex_memread_i,
   input  logic [REG_W-1:0]  ex_rt_i,
   input  logic              flush_i,
   input  logic              freeze_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              bubble_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

   typedef enum logic {IDLE, STALL} state_t;

   // The first stall cycle is spent in IDLE, so STALL covers the remaining LOAD_STALL-1.
   localparam logic [2:0] STALL_INIT = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;

   state_t     state;
   logic [2:0] cnt;
   logic       hz;

   assign hz = ex_memread_i && (ex_rt_i != '0) &&
               ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

   always_comb begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_o     = 1'b0;
      if (rst_i || freeze_i) begin
         pc_write_o   = 1'b0;
      end else if (flush_i) begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         bubble_o     = 1'b1;
      end else if (state == STALL || hz) begin
         bubble_o     = 1'b1;
      end else begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_o <= '0;
         state  <= IDLE;
         cnt    <= 3'd0;
      end else if (freeze_i) begin
         ctrl_o <= ctrl_o;
      end else if (flush_i) begin
         ctrl_o <= '0;
         state  <= IDLE;
         cnt    <= 3'd0;
      end else if (state == STALL) begin
         ctrl_o <= '0;
         if (cnt == 3'd0) begin
            state <= IDLE;
         end else begin
            cnt <= cnt - 3'd1;
         end
      end else if (hz) begin
         ctrl_o <= '0;
         if (LOAD_STALL > 1) begin
            state <= STALL;
            cnt   <= STALL_INIT;
         end
      end else begin
         ctrl_o <= ctrl_i;
      end
   end

`ifdef HAZARD_STATS_EN
   // Saturating count of bubbles inserted into ID/EX.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_o <= '0;
      end else if (bubble_o && (bubble_cnt_o != {CNT_W{1'b1}})) begin
         bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// tb/tb_hazard_bubble_ctrl.sv - self-checking bench for hazard_bubble_ctrl
// Two instances (LOAD_STALL=1 with CNT_W=2, LOAD_STALL=3) share one stimulus stream.
module tb_hazard_bubble_ctrl;
   localparam int CW = 12;
   localparam int RW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [CW-1:0] ctrl_i = '0;
   logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic          id_uses_rt = 1'b0, ex_memread = 1'b0, flush = 1'b0, freeze = 1'b0;

   logic [CW-1:0] ctrl1, ctrl3;
   logic          pc1, pc3, if1, if3, b1, b3;
`ifdef HAZARD_STATS_EN
   logic [1:0]    bc1;
   logic [15:0]   bc3;
`endif

   int total = 0;
   int bad   = 0;

   // Reference state: stall cycles still owed after the current one, expected ID/EX bundle, bubbles seen.
   int            rem1 = 0, rem3 = 0;
   logic [CW-1:0] ce1 = '0, ce3 = '0;
   int            n1 = 0, n3 = 0;
   int            stall3_len = 0;

   hazard_bubble_ctrl #(.CTRL_W(CW), .REG_W(RW), .LOAD_STALL(1), .CNT_W(2)) u1 (
      .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
      .flush_i(flush), .freeze_i(freeze), .ctrl_o(ctrl1), .pc_write_o(pc1),
      .ifid_write_o(if1), .bubble_o(b1)
`ifdef HAZARD_STATS_EN
      , .bubble_cnt_o(bc1)
`endif
   );

   hazard_bubble_ctrl #(.CTRL_W(CW), .REG_W(RW), .LOAD_STALL(3), .CNT_W(16)) u3 (
      .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
      .flush_i(flush), .freeze_i(freeze), .ctrl_o(ctrl3), .pc_write_o(pc3),
      .ifid_write_o(if3), .bubble_o(b3)
`ifdef HAZARD_STATS_EN
      , .bubble_cnt_o(bc3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic hz_now();
      return ex_memread && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   // Expected {pc_write, ifid_write, bubble} for this cycle.
   function automatic logic [2:0] exp_out(input int rem);
      if (rst || freeze) return 3'b000;
      if (flush) return 3'b111;
      if (rem > 0 || hz_now()) return 3'b001;
      return 3'b110;
   endfunction

   task automatic adv(input int ls, input int cmax, inout int rem,
                      inout logic [CW-1:0] ce, inout int n);
      if (rst || freeze) return;
      if (flush) begin
         rem = 0; ce = '0; if (n < cmax) n++;
      end else if (rem > 0) begin
         rem--; ce = '0; if (n < cmax) n++;
      end else if (hz_now()) begin
         rem = ls - 1; ce = '0; if (n < cmax) n++;
      end else begin
         ce = ctrl_i;
      end
   endtask

   task automatic tick();
      logic [2:0] e1, e3;
      @(negedge clk);
      if (rst) begin
         rem1 = 0; rem3 = 0; ce1 = '0; ce3 = '0; n1 = 0; n3 = 0;
      end
      e1 = exp_out(rem1);
      e3 = exp_out(rem3);
      chk("ctrl_ls1", 32'(ctrl1), 32'(ce1));
      chk("outs_ls1", 32'({pc1, if1, b1}), 32'(e1));
      chk("ctrl_ls3", 32'(ctrl3), 32'(ce3));
      chk("outs_ls3", 32'({pc3, if3, b3}), 32'(e3));
`ifdef HAZARD_STATS_EN
      chk("bcnt_ls1", 32'(bc1), n1);
      chk("bcnt_ls3", 32'(bc3), n3);
`endif
      if (!rst && !pc3) stall3_len++;
      adv(1, 3, rem1, ce1, n1);
      adv(3, 65535, rem3, ce3, n3);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic fr, input logic fl, input logic mr,
                        input logic [RW-1:0] ert, input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt, input logic urt, input logic [CW-1:0] c);
      rst = r; freeze = fr; flush = fl; ex_memread = mr;
      ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt; ctrl_i = c;
   endtask

   initial begin
      // Reset with all-ones bundle on the input
      drive(1, 0, 0, 0, 0, 0, 0, 0, 12'hFFF);
      tick(); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h0A5);
      tick(); tick();

      // Load-use on rs
      drive(0, 0, 0, 1, 8, 8, 3, 0, 12'h123);
      tick();
      drive(0, 0, 0, 0, 8, 8, 3, 0, 12'h456);
      tick(); tick(); tick(); tick();

      // Multi-cycle stall length on the LOAD_STALL=3 instance
      stall3_len = 0;
      drive(0, 0, 0, 1, 8, 8, 3, 0, 12'h321);
      tick();
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'h654);
      tick(); tick(); tick(); tick(); tick();
      chk("stall3_len", stall3_len, 3);

      // rt source qualification and ex_rt==0
      drive(0, 0, 0, 1, 9, 1, 9, 0, 12'h111);
      tick();
      drive(0, 0, 0, 1, 9, 1, 9, 1, 12'h222);
      tick();
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'h333);
      tick(); tick(); tick();
      drive(0, 0, 0, 1, 0, 0, 0, 1, 12'h444);
      tick(); tick();

      // Freeze for two cycles in stall cycle 2
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'h555);
      tick(); tick();
      drive(0, 0, 0, 1, 7, 7, 2, 0, 12'h666);
      tick();
      drive(0, 1, 0, 0, 0, 1, 2, 0, 12'h777);
      tick(); tick();
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'h888);
      tick(); tick(); tick(); tick();

      // Flush concurrent with hazard, then during an active stall
      drive(0, 0, 1, 1, 8, 8, 3, 0, 12'h999);
      tick();
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'hAAA);
      tick();
      drive(0, 0, 0, 1, 8, 8, 3, 0, 12'hBBB);
      tick();
      drive(0, 0, 1, 0, 0, 1, 2, 0, 12'hCCC);
      tick();
      drive(0, 0, 0, 0, 0, 1, 2, 0, 12'hDDD);
      tick(); tick();

      // Five isolated bubbles after reset saturate a 2-bit counter
      drive(1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 4, 4, 0, 0, 12'h0F0);
         tick();
         drive(0, 0, 0, 0, 0, 1, 2, 0, 12'h00F);
         tick(); tick(); tick();
      end
`ifdef HAZARD_STATS_EN
      @(negedge clk);
      chk("bcnt_sat", 32'(bc1), 3);
      @(posedge clk);
      #1;
`endif

      // Randomized traffic with occasional reset mid-stall
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
               RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
               RW'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
               CW'($urandom));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
